// File: rtl/timer_pkg.sv
// Shared BCD digit type and helpers for the timer datapath.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Non-decimal nibbles (A..F) saturate to 9 so the counter never holds an illegal digit.
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One loadable BCD digit of a ripple-borrow down-counter.
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic       borrow_in,
  input  logic [3:0] din,
  output logic [3:0] q,
  output logic       zero,
  output logic       borrow_out
);

  bcd_t q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= bcd_clamp(din);
    end else if (dec && borrow_in) begin
      // A digit at 0 wraps to 9 and passes the borrow upward.
      q_reg <= (q_reg == 4'd0) ? BCD_MAX : q_reg - 4'd1;
    end
  end

  assign q          = q_reg;
  assign zero       = (q_reg == 4'd0);
  assign borrow_out = dec & borrow_in & zero;

endmodule

// File: rtl/timer_bcd_counter.sv
// Loadable BCD down-counter with prescaler; reports zero back to the timer FSM.
module timer_bcd_counter
  import timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe,
  input  logic                  ce,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic                  ifequal,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tick
);

  localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc_reg;
  logic [PSC_W-1:0] psc_next;
  logic             psc_last;
  logic             dec;
  logic [DIGITS-1:0] zero_vec;
  logic [DIGITS:0]   borrow_chain;
  logic              unused_top_borrow;

  assign psc_last = (psc_reg == PSC_LAST);
  assign tick     = ce & ~pe & psc_last;

  // Any cycle without a clean count enable restarts a full prescale period.
  always_comb begin
    psc_next = '0;
    if (!pe && ce && !psc_last) begin
      psc_next = psc_reg + PSC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_reg <= '0;
    end else begin
      psc_reg <= psc_next;
    end
  end

  // Holding at zero instead of wrapping to all nines.
  assign dec             = tick & ~ifequal;
  assign borrow_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_down u_digit (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pe),
        .dec        (dec),
        .borrow_in  (borrow_chain[gi]),
        .din        (load_val[gi*4 +: 4]),
        .q          (cnt[gi*4 +: 4]),
        .zero       (zero_vec[gi]),
        .borrow_out (borrow_chain[gi+1])
      );
    end
  endgenerate

  // The top digit's borrow can never fire because decrement is blocked at zero.
  assign unused_top_borrow = borrow_chain[DIGITS];

  assign ifequal = &zero_vec;

endmodule

// File: tb/tb_timer_bcd_counter.sv
// Directed and random checks of timer_bcd_counter against a decimal reference model.
module tb_timer_bcd_counter;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pe = 1'b0;
  logic       ce = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       ifequal;
  logic [7:0] cnt;
  logic       tick;

  int checks = 0;
  int errors = 0;

  // Reference: count value as a plain integer, and length of the current enable run.
  int    model_val = 0;
  int    model_run = 0;
  string phase = "reset";

  always #5 clk = ~clk;

  timer_bcd_counter #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pe       (pe),
    .ce       (ce),
    .load_val (load_val),
    .ifequal  (ifequal),
    .cnt      (cnt),
    .tick     (tick)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int clamp_val(input logic [7:0] lv);
    int hi;
    int lo;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  // Drive one cycle at posedge+1, check tick mid-cycle, then the registered state after the edge.
  task automatic cycle(input logic p, input logic c, input logic [7:0] lv);
    logic exp_tick;
    pe       = p;
    ce       = c;
    load_val = lv;
    exp_tick = (!p && c && ((model_run + 1) % PRESCALE == 0)) ? 1'b1 : 1'b0;
    #4;
    check("tick", 32'(tick), 32'(exp_tick));
    @(posedge clk);
    if (p) begin
      model_val = clamp_val(lv);
      model_run = 0;
    end else if (c) begin
      model_run++;
      if (exp_tick && model_val > 0) model_val--;
    end else begin
      model_run = 0;
    end
    #1;
    check("cnt", 32'(cnt), 32'(to_bcd(model_val)));
    check("ifequal", 32'(ifequal), (model_val == 0) ? 32'd1 : 32'd0);
    $display("[%0t] %s pe=%0b ce=%0b load=%02h -> cnt=%02h ifequal=%0b", $time, phase, p, c, lv, cnt, ifequal);
  endtask

  initial begin
    int n;
    logic td;

    // Reset held from time zero, before any clock edge.
    ce = 1'b1;
    #2;
    check("rst_cnt", 32'(cnt), 32'h00);
    check("rst_ifequal", 32'(ifequal), 32'd1);
    check("rst_tick", 32'(tick), 32'd0);
    ce = 1'b0;
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;

    phase = "load_count";
    cycle(1'b1, 1'b0, 8'h12);
    for (int i = 0; i < 12 * PRESCALE + 6; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    phase = "clamp_borrow";
    cycle(1'b1, 1'b0, 8'hAF);
    for (int i = 0; i < PRESCALE; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 8'h10);
    for (int i = 0; i < PRESCALE; i++) cycle(1'b0, 1'b1, 8'h00);
    check("borrow_result", 32'(cnt), 32'h09);

    phase = "psc_restart";
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < PRESCALE; i++) cycle(1'b0, 1'b1, 8'h00);

    phase = "load_priority";
    cycle(1'b1, 1'b0, 8'h55);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'h34);
    for (int i = 0; i < PRESCALE; i++) cycle(1'b0, 1'b1, 8'h00);

    phase = "zero_load";
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 2 * PRESCALE; i++) cycle(1'b0, 1'b1, 8'h00);

    // Minimal stand-in for the timer FSM: st loads the preset, then counts until ifequal.
    phase = "closed_loop";
    cycle(1'b1, 1'b0, 8'h03);
    n = 0;
    while (!ifequal && n < 100) begin
      cycle(1'b0, 1'b1, 8'h00);
      n++;
    end
    td = ifequal;
    cycle(1'b0, 1'b0, 8'h00);
    check("loop_cycles", 32'(n), 32'(3 * PRESCALE));
    check("loop_td", 32'(td), 32'd1);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            8'($urandom));
    end

    phase = "reset_mid";
    cycle(1'b1, 1'b0, 8'h47);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    ce = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cnt", 32'(cnt), 32'h00);
    check("rst_mid_ifequal", 32'(ifequal), 32'd1);
    check("rst_mid_tick", 32'(tick), 32'd0);
    model_val = 0;
    model_run = 0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 8'h05);
    for (int i = 0; i < PRESCALE; i++) cycle(1'b0, 1'b1, 8'h00);
    check("rst_mid_restart", 32'(cnt), 32'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
